// File: rtl/seg7_bcd_reader_if.sv
// Display-bus interface: segment/select lines in, decoded frame snapshot out.
interface seg7_bcd_reader_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    frame_valid;
  logic                    sel_err;

  // Side driving the display bus and consuming the snapshot.
  modport master (
    output seg_in, dig_sel,
    input  bcd_out, digit_err, frame_valid, sel_err
  );

  // The reader itself.
  modport slave (
    input  seg_in, dig_sel,
    output bcd_out, digit_err, frame_valid, sel_err
  );
endinterface

// File: rtl/seg7_bcd_reader.sv
// Recovers BCD digits from a multiplexed active-high 7-segment bus and publishes
// one snapshot per complete scan frame.
module seg7_bcd_reader #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input logic               clk,
  input logic               rst_n,
  seg7_bcd_reader_if.slave  bus
);

  localparam int unsigned CntW  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned SampW = NUM_DIGITS + 7;

  typedef enum logic [1:0] {StIdle, StSettle, StLocked} state_e;

  state_e                          state_d, state_q;
  logic [SampW-1:0]                samp_d, samp_q;
  logic [CntW-1:0]                 cnt_d, cnt_q;
  logic                            changed, commit, frame_done;
  logic [NUM_DIGITS-1:0]           sel_q;
  logic [6:0]                      seg_q;
  logic [4:0]                      dec;

  logic [NUM_DIGITS-1:0][3:0]      slot_d, slot_q;
  logic [NUM_DIGITS-1:0]           slot_err_d, slot_err_q;
  logic [NUM_DIGITS-1:0]           seen_d, seen_q;
  logic [NUM_DIGITS-1:0][3:0]      bcd_d, bcd_q;
  logic [NUM_DIGITS-1:0]           derr_d, derr_q;
  logic                            fv_d, fv_q;
  logic                            serr_d, serr_q;

  // Returns {err, bcd}; blank maps to E, anything unrecognised to F with err.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h7E:   seg_decode = 5'h00;
      7'h30:   seg_decode = 5'h01;
      7'h6D:   seg_decode = 5'h02;
      7'h79:   seg_decode = 5'h03;
      7'h33:   seg_decode = 5'h04;
      7'h5B:   seg_decode = 5'h05;
      7'h5F:   seg_decode = 5'h06;
      7'h70:   seg_decode = 5'h07;
      7'h7F:   seg_decode = 5'h08;
      7'h7B:   seg_decode = 5'h09;
      7'h00:   seg_decode = 5'h0E;
      default: seg_decode = 5'h1F;
    endcase
  endfunction

  assign sel_q = samp_q[SampW-1:7];
  assign seg_q = samp_q[6:0];
  assign dec   = seg_decode(seg_q);

  // Input stage: capture the bus and track how long it has been unchanged.
  always_comb begin
    samp_d  = {bus.dig_sel, bus.seg_in};
    changed = (samp_d != samp_q);
    if (changed) begin
      cnt_d = CntW'(1);
    end else if (cnt_q == CntW'(STABLE_CYCLES)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // FSM next state; commit fires once per stable run of a selected digit.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.dig_sel != '0) state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == CntW'(STABLE_CYCLES)) begin
          commit  = 1'b1;
          state_d = StLocked;
        end
        if (changed) state_d = (bus.dig_sel == '0) ? StIdle : StSettle;
      end
      StLocked: begin
        if (changed) state_d = (bus.dig_sel == '0) ? StIdle : StSettle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Slot collection and frame snapshot; the snapshot takes slots before this edge's commit.
  always_comb begin
    frame_done = &seen_q;
    slot_d     = slot_q;
    slot_err_d = slot_err_q;
    seen_d     = frame_done ? '0 : seen_q;
    bcd_d      = frame_done ? slot_q : bcd_q;
    derr_d     = frame_done ? slot_err_q : derr_q;
    fv_d       = frame_done;
    serr_d     = 1'b0;
    if (commit) begin
      if ($onehot(sel_q)) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (sel_q[i]) begin
            slot_d[i]     = dec[3:0];
            slot_err_d[i] = dec[4];
            seen_d[i]     = 1'b1;
          end
        end
      end else begin
        serr_d = 1'b1;
      end
    end
  end

  // Sample register, stability counter and FSM state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_q  <= '0;
      cnt_q   <= '0;
      state_q <= StIdle;
    end else begin
      samp_q  <= samp_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Slots, seen mask and published outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q     <= '0;
      slot_err_q <= '0;
      seen_q     <= '0;
      bcd_q      <= '0;
      derr_q     <= '0;
      fv_q       <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      slot_err_q <= slot_err_d;
      seen_q     <= seen_d;
      bcd_q      <= bcd_d;
      derr_q     <= derr_d;
      fv_q       <= fv_d;
      serr_q     <= serr_d;
    end
  end

  assign bus.bcd_out     = bcd_q;
  assign bus.digit_err   = derr_q;
  assign bus.frame_valid = fv_q;
  assign bus.sel_err     = serr_q;

endmodule

// File: tb/tb_seg7_bcd_reader.sv
// Bench for seg7_bcd_reader: directed scenarios plus random bursts, every cycle
// compared against a run-length reference model of the display bus.
module tb_seg7_bcd_reader;

  localparam int unsigned N = 4;
  localparam int unsigned S = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_bcd_reader_if #(.NUM_DIGITS(N)) bus ();

  seg7_bcd_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fv_cnt = 0;
  int fv_cyc = -1;
  int se_cnt = 0;

  logic [6:0] pat [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                           7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  logic [3:0] bad_sel [8] = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC, 4'h7, 4'hF};

  // Reference model state: history of the bus as runs of identical samples.
  logic [10:0] m_prev = '0;
  int          m_run  = 0;
  bit          m_pend_c = 0;
  logic [10:0] m_pc = '0;
  bit          m_pend_f = 0;
  logic [3:0]  m_slot [N];
  bit          m_serr [N];
  bit          m_seen [N];
  logic [15:0] m_bcd = '0;
  logic [3:0]  m_err = '0;
  bit          m_fv = 0;
  bit          m_se = 0;

  function automatic logic [4:0] ref_dec(input logic [6:0] p);
    for (int d = 0; d < 10; d++) if (pat[d] == p) return {1'b0, 4'(d)};
    if (p == 7'h00) return 5'h0E;
    return 5'h1F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_edge(input logic rn, input logic [3:0] sel, input logic [6:0] seg);
    logic [4:0] d;
    int all;
    if (!rn) begin
      m_prev = '0; m_run = 0; m_pend_c = 0; m_pend_f = 0;
      m_bcd = '0; m_err = '0; m_fv = 0; m_se = 0;
      for (int i = 0; i < N; i++) begin m_slot[i] = '0; m_serr[i] = 0; m_seen[i] = 0; end
      return;
    end
    m_fv = m_pend_f;
    m_se = 0;
    if (m_pend_f) begin
      for (int i = 0; i < N; i++) begin
        m_bcd[4*i +: 4] = m_slot[i];
        m_err[i] = m_serr[i];
        m_seen[i] = 0;
      end
    end
    m_pend_f = 0;
    if (m_pend_c) begin
      if ($countones(m_pc[10:7]) == 1) begin
        d = ref_dec(m_pc[6:0]);
        for (int i = 0; i < N; i++) begin
          if (m_pc[7+i]) begin m_slot[i] = d[3:0]; m_serr[i] = d[4]; m_seen[i] = 1; end
        end
        all = 1;
        for (int i = 0; i < N; i++) if (!m_seen[i]) all = 0;
        if (all == 1) m_pend_f = 1;
      end else begin
        m_se = 1;
      end
    end
    m_pend_c = 0;
    if ({sel, seg} == m_prev) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_run = 1;
    end
    m_prev = {sel, seg};
    if (m_run == S && sel != '0) begin m_pend_c = 1; m_pc = {sel, seg}; end
  endtask

  task automatic step(input logic rn, input logic [3:0] sel, input logic [6:0] seg);
    rst_n = rn;
    bus.dig_sel = sel;
    bus.seg_in = seg;
    cyc++;
    @(posedge clk);
    model_edge(rn, sel, seg);
    #1;
    chk("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
    chk("sel_err", 32'(bus.sel_err), 32'(m_se));
    chk("bcd_out", 32'(bus.bcd_out), 32'(m_bcd));
    chk("digit_err", 32'(bus.digit_err), 32'(m_err));
    if (bus.frame_valid === 1'b1) begin fv_cnt++; fv_cyc = cyc; end
    if (bus.sel_err === 1'b1) se_cnt++;
  endtask

  task automatic digit(input int pos, input logic [6:0] seg, input int hold, input int blank);
    for (int k = 0; k < hold; k++) step(1'b1, 4'(1 << pos), seg);
    for (int k = 0; k < blank; k++) step(1'b1, 4'h0, 7'(($urandom)));
  endtask

  initial begin
    int c0;
    logic [3:0] sel;
    logic [6:0] seg;
    int r;

    // Reset with random inputs, then release on a blank bus.
    for (int k = 0; k < 3; k++) step(1'b0, 4'($urandom), 7'($urandom));
    chk("rst_bcd", 32'(bus.bcd_out), 32'h0);
    chk("rst_err", 32'(bus.digit_err), 32'h0);
    chk("rst_fv", 32'(bus.frame_valid), 32'h0);
    chk("rst_se", 32'(bus.sel_err), 32'h0);
    fv_cnt = 0; se_cnt = 0;
    for (int k = 0; k < 4; k++) step(1'b1, 4'h0, 7'h00);
    chk("rst_nopulse", 32'(fv_cnt + se_cnt), 32'h0);

    // Nominal scan 1,2,3,4.
    fv_cnt = 0;
    digit(0, 7'h30, 5, 1);
    digit(1, 7'h6D, 5, 1);
    digit(2, 7'h79, 5, 1);
    c0 = cyc + 1;
    digit(3, 7'h33, 5, 1);
    chk("nom_pulses", 32'(fv_cnt), 32'd1);
    chk("nom_latency", 32'(fv_cyc), 32'(c0 + S + 1));
    chk("nom_bcd", 32'(bus.bcd_out), 32'h4321);
    chk("nom_err", 32'(bus.digit_err), 32'h0);

    // Glitch rejection: 7F for two samples must never land in slot 0.
    fv_cnt = 0;
    for (int k = 0; k < 5; k++) step(1'b1, 4'h1, 7'h7E);
    for (int k = 0; k < 2; k++) step(1'b1, 4'h1, 7'h7F);
    digit(0, 7'h7E, 5, 1);
    chk("glitch_nofv", 32'(fv_cnt), 32'd0);
    digit(1, 7'h30, 4, 1);
    digit(2, 7'h6D, 4, 1);
    digit(3, 7'h79, 4, 2);
    chk("glitch_pulses", 32'(fv_cnt), 32'd1);
    chk("glitch_bcd", 32'(bus.bcd_out), 32'h3210);

    // Illegal and blank patterns.
    fv_cnt = 0;
    digit(0, 7'h5B, 4, 1);
    digit(1, 7'h55, 4, 1);
    digit(2, 7'h00, 4, 1);
    digit(3, 7'h70, 4, 2);
    chk("ill_pulses", 32'(fv_cnt), 32'd1);
    chk("ill_bcd", 32'(bus.bcd_out), 32'h7EF5);
    chk("ill_err", 32'(bus.digit_err), 32'h2);

    // Non-one-hot select held for exactly the stability window.
    fv_cnt = 0; se_cnt = 0;
    for (int k = 0; k < 3; k++) step(1'b1, 4'h3, 7'h30);
    for (int k = 0; k < 3; k++) step(1'b1, 4'h0, 7'h00);
    chk("selerr_pulses", 32'(se_cnt), 32'd1);
    chk("selerr_nofv", 32'(fv_cnt), 32'd0);
    chk("selerr_bcd", 32'(bus.bcd_out), 32'h7EF5);

    // Overwrite of slot 0 before the frame completes.
    fv_cnt = 0;
    digit(0, 7'h5B, 4, 1);
    digit(0, 7'h7B, 4, 1);
    digit(1, 7'h30, 4, 1);
    digit(2, 7'h6D, 4, 1);
    digit(3, 7'h79, 4, 2);
    chk("ovr_pulses", 32'(fv_cnt), 32'd1);
    chk("ovr_bcd", 32'(bus.bcd_out), 32'h3219);

    // Reset after two digits; only the following full frame may publish.
    fv_cnt = 0;
    digit(0, 7'h33, 4, 1);
    digit(1, 7'h79, 4, 1);
    step(1'b0, 4'h2, 7'h79);
    step(1'b0, 4'h0, 7'h00);
    chk("mid_rst_bcd", 32'(bus.bcd_out), 32'h0);
    digit(0, 7'h5B, 4, 1);
    digit(1, 7'h5F, 4, 1);
    digit(2, 7'h70, 4, 1);
    digit(3, 7'h7F, 4, 2);
    chk("mid_pulses", 32'(fv_cnt), 32'd1);
    chk("mid_bcd", 32'(bus.bcd_out), 32'h8765);

    // Random bursts: legal, blank, illegal patterns, bad selects, glitches, resets.
    for (int b = 0; b < 400; b++) begin
      if ($urandom_range(0, 9) == 0) sel = bad_sel[$urandom_range(0, 7)];
      else sel = 4'(1 << $urandom_range(0, N - 1));
      r = int'($urandom_range(0, 11));
      if (r < 10) seg = pat[r];
      else if (r == 10) seg = 7'h00;
      else seg = 7'($urandom);
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) step(1'b1, sel, seg);
      if ($urandom_range(0, 39) == 0) step(1'b0, 4'($urandom), 7'($urandom));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) step(1'b1, 4'h0, 7'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
